fifo_axis_reader: RTL and testbench

- Read-side adapter between the synchronous FIFO (rd_en/empty/data_out, registered read, 1-cycle read latency) and the downstream AXI-Stream consumer, the I2C master command port.
- Pops words from the FIFO and presents them on an AXI-Stream master interface.
- A 2-entry output buffer absorbs the FIFO read latency and sustains 1 word/cycle with no bubbles and no lost words under arbitrary tready back-pressure.

---
 rtl/fifo_axis_reader.sv | 123 ++++++++++++
 tb/tb_fifo_axis_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_axis_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_axis_reader
//  Description : Read-side adapter from a synchronous FIFO (registered read,
//                1-cycle latency) to an AXI-Stream master. A 2-entry output
//                buffer with credit-based read issue sustains one word per
//                cycle and never drops a word under back-pressure.
//                Optional packet framing (m_axis_tlast every PKT_LEN words)
//                is enabled by defining FIFO_AXIS_TLAST_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 15,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
`ifdef FIFO_AXIS_TLAST_EN
    ,
    output logic                  m_axis_tlast
`endif
);

    // Packet length of zero makes framing meaningless; reject at elaboration.
    if (PKT_LEN < 1) begin : g_pkt_len_check
        $error("fifo_axis_reader: PKT_LEN must be >= 1");
    end

    logic [1:0]            cnt;       // words held in the output buffer
    logic                  inflight;  // FIFO read issued in the previous cycle
    logic [DATA_WIDTH-1:0] tail;      // second buffer slot; head is m_axis_tdata
    logic                  pop;
    logic [2:0]            occupancy; // buffered + in-flight words after this edge
    logic [1:0]            cnt_next;

    // Credit check: a new read is issued only if the word it returns next
    // cycle is guaranteed a free slot, counting the pop happening now.
    always_comb begin
        pop        = m_axis_tvalid & m_axis_tready;
        occupancy  = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};
        cnt_next   = occupancy[1:0];
        fifo_rd_en = ~arst & ~fifo_empty & (occupancy < 3'd2);
    end

    // Buffer occupancy, in-flight tracking and registered valid.
    always_ff @(posedge clk) begin
        if (arst) begin
            cnt           <= 2'd0;
            inflight      <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            inflight      <= fifo_rd_en;
            m_axis_tvalid <= (cnt_next != 2'd0);
        end
    end

    // Head/tail data movement: the returning FIFO word lands in the first
    // slot that is free after this edge's pop, so order is preserved.
    always_ff @(posedge clk) begin
        if (arst) begin
            m_axis_tdata <= '0;
            tail         <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        m_axis_tdata <= fifo_data;
                    end else begin
                        tail <= fifo_data;
                    end
                end
                2'b01: begin
                    if (cnt == 2'd2) begin
                        m_axis_tdata <= tail;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        m_axis_tdata <= fifo_data;
                    end else begin
                        m_axis_tdata <= tail;
                        tail         <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_AXIS_TLAST_EN
    localparam int                 PKT_CW   = $clog2(PKT_LEN) + 1;
    localparam logic [PKT_CW-1:0]  PKT_LAST = PKT_CW'(PKT_LEN - 1);

    logic [PKT_CW-1:0] pkt_cnt;       // index of the head word within its packet

    // Packet position advances only on a pop, so tlast is stall-stable.
    always_ff @(posedge clk) begin
        if (arst) begin
            pkt_cnt <= '0;
        end else if (pop) begin
            if (pkt_cnt == PKT_LAST) begin
                pkt_cnt <= '0;
            end else begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end

    // tlast qualified by valid so it reads 0 whenever the buffer is empty.
    always_comb begin
        m_axis_tlast = m_axis_tvalid & (pkt_cnt == PKT_LAST);
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_axis_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_axis_reader
//  Description : Directed self-checking bench for fifo_axis_reader with a
//                behavioural 1-cycle-latency FIFO and an output scoreboard.
//                Define FIFO_AXIS_TLAST_EN to also check packet framing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_axis_reader;

    localparam int DW      = 15;
    localparam int PKT_LEN = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    fifo_axis_reader #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PKT_LEN)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef FIFO_AXIS_TLAST_EN
        ,
        .m_axis_tlast  (m_axis_tlast)
`endif
    );

`ifndef FIFO_AXIS_TLAST_EN
    assign m_axis_tlast = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [DW-1:0] fq[$];     // contents of the modelled FIFO
    logic [DW-1:0] exp_q[$];  // words expected on the stream, in order
    int            checks     = 0;
    int            failures   = 0;
    int            pops       = 0;
    int            pkt_idx    = 0;
    int            tlast_pops = 0;
    logic          rd_s       = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_tlast = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // Mid-cycle sampling plus the always-on monitor checks.
    task automatic sample();
        logic [DW-1:0] e;
        @(negedge clk);
        rd_s = fifo_rd_en;
        check("rd_on_empty", {31'b0, fifo_rd_en & fifo_empty}, 32'd0);
        if (arst !== 1'b1) begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, m_axis_tvalid}, 32'd1);
                check("stall_data", {17'b0, m_axis_tdata}, {17'b0, prev_data});
`ifdef FIFO_AXIS_TLAST_EN
                check("stall_tlast", {31'b0, m_axis_tlast}, {31'b0, prev_tlast});
`endif
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                pops++;
                check("pop_has_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("pop_data", {17'b0, m_axis_tdata}, {17'b0, e});
                end
`ifdef FIFO_AXIS_TLAST_EN
                check("tlast", {31'b0, m_axis_tlast}, {31'b0, pkt_idx == PKT_LEN - 1});
                if (m_axis_tlast === 1'b1) tlast_pops++;
`endif
                pkt_idx = (pkt_idx + 1) % PKT_LEN;
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_tlast = m_axis_tlast;
        end else begin
            prev_stall = 1'b0;
            pkt_idx    = 0;
        end
    endtask

    // Clock edge, then the FIFO model returns the word read at that edge.
    task automatic advance();
        @(posedge clk);
        #1;
        if (rd_s && fq.size() != 0) fifo_data = fq.pop_front();
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        int n;
        int rdc;
        int p0;

        arst          = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data     = '0;
        m_axis_tready = 1'b0;
        tick();

        // Reset held with a non-empty FIFO: no reads, outputs cleared.
        push(15'h1234);
        for (int i = 0; i < 2; i++) begin
            sample();
            check("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
            check("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
            check("rst_tdata", {17'b0, m_axis_tdata}, 32'd0);
            advance();
        end

        // Release: read in cycle N, valid in N+2, single beat.
        arst          = 1'b0;
        m_axis_tready = 1'b1;
        sample();
        check("lat_rd_N", {31'b0, fifo_rd_en}, 32'd1);
        check("lat_valid_N", {31'b0, m_axis_tvalid}, 32'd0);
        advance();
        sample();
        check("lat_rd_N1", {31'b0, fifo_rd_en}, 32'd0);
        check("lat_valid_N1", {31'b0, m_axis_tvalid}, 32'd0);
        advance();
        sample();
        check("lat_valid_N2", {31'b0, m_axis_tvalid}, 32'd1);
        check("lat_data_N2", {17'b0, m_axis_tdata}, 32'h1234);
        advance();
        sample();
        check("lat_valid_N3", {31'b0, m_axis_tvalid}, 32'd0);
        advance();

        // Streaming: 5 words back to back with tready high.
        for (int i = 1; i <= 5; i++) push(DW'(i));
        n = 0;
        sample();
        while (m_axis_tvalid !== 1'b1 && n < 20) begin
            advance();
            sample();
            n++;
        end
        check("stream_latency", n, 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("stream_valid", {31'b0, m_axis_tvalid}, 32'd1);
            advance();
            sample();
        end
        check("stream_end", {31'b0, m_axis_tvalid}, 32'd0);
        advance();

        // Back-pressure: 4 words, tready low for 6 cycles.
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) push(DW'(i));
        rdc = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            if (fifo_rd_en === 1'b1) rdc++;
            advance();
        end
        check("bp_rd_pulses", rdc, 32'd2);
        sample();
        check("bp_valid", {31'b0, m_axis_tvalid}, 32'd1);
        check("bp_data", {17'b0, m_axis_tdata}, 32'd1);
        check("bp_rd_held", {31'b0, fifo_rd_en}, 32'd0);
        advance();
        m_axis_tready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 8; i++) tick();
        check("bp_pop_count", pops - p0, 32'd4);
        check("bp_drained", exp_q.size(), 32'd0);

        // Random back-pressure and random FIFO fill over 200 words.
        p0 = 0;
        n  = 0;
        rdc = pops;
        while ((p0 < 200 || exp_q.size() != 0) && n < 3000) begin
            if (p0 < 200 && $urandom_range(0, 1) == 1) begin
                push(DW'($urandom_range(0, 32767)));
                p0++;
            end
            m_axis_tready = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        check("rand_drained", exp_q.size(), 32'd0);
        check("rand_pop_count", pops - rdc, 32'd200);

        // Reset mid-operation discards buffered and in-flight words.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) push(DW'(15'h0a0 + i));
        for (int i = 0; i < 4; i++) tick();
        arst = 1'b1;
        sample();
        check("midrst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        advance();
        fq.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        arst       = 1'b0;
        sample();
        check("midrst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        check("midrst_tdata", {17'b0, m_axis_tdata}, 32'd0);
        advance();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        sample();
        check("midrst_idle", {31'b0, m_axis_tvalid}, 32'd0);
        advance();

        // Eight words with toggling tready; framing checked by the monitor.
        tlast_pops = 0;
        for (int i = 0; i < 8; i++) push(DW'(15'h100 + i));
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            m_axis_tready = (n % 3 != 1);
            tick();
            n++;
        end
        check("pkt_drained", exp_q.size(), 32'd0);
`ifdef FIFO_AXIS_TLAST_EN
        check("pkt_tlast_count", tlast_pops, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
